// File: rtl/cascaded_mod_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : cascaded_mod_counter_if
// Brief    : Control and status bundle for the cascaded modulo counter.
// Revision : 1.0 - initial release
// ============================================================================
interface cascaded_mod_counter_if #(
    parameter int DIGITS = 2,
    parameter int W      = 5
);
    logic                 En;
    logic                 Up;
    logic                 Clear;
    logic                 Load;
    logic [DIGITS*W-1:0]  LoadVal;
    logic                 ModWr;
    logic [W-1:0]         Mod;
    logic [DIGITS*W-1:0]  Q;
    logic                 Rollover;
    logic [DIGITS-1:0]    DigitCarry;
    logic                 Overflow;
    logic                 LoadErr;
    logic [W-1:0]         ModCur;

    modport master (
        output En, Up, Clear, Load, LoadVal, ModWr, Mod,
        input  Q, Rollover, DigitCarry, Overflow, LoadErr, ModCur
    );

    modport slave (
        input  En, Up, Clear, Load, LoadVal, ModWr, Mod,
        output Q, Rollover, DigitCarry, Overflow, LoadErr, ModCur
    );
endinterface
`default_nettype wire

// File: rtl/cascaded_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : cascaded_mod_counter
// Brief    : DIGITS-digit up/down counter sharing one run-time modulus.
// Revision : 1.0 - initial release
// ============================================================================
module cascaded_mod_counter #(
    parameter int DIGITS = 2,
    parameter int W      = 5,
    parameter int K      = 20
) (
    input  wire logic              Clk,
    input  wire logic              Reset,
    cascaded_mod_counter_if.slave  bus
);
    localparam logic [W-1:0] c_one       = W'(1);
    localparam logic [W-1:0] c_min_mod   = W'(2);
    localparam logic [W-1:0] c_reset_mod = W'(K);

    logic [DIGITS*W-1:0] r_q;
    logic [DIGITS*W-1:0] w_q_next;
    logic [W-1:0]        r_mod;
    logic [W-1:0]        w_new_mod;
    logic [W-1:0]        w_eff_mod;
    logic [W-1:0]        w_mod_m1;
    logic [W-1:0]        w_eff_m1;
    logic                r_ovf;
    logic                r_lerr;
    logic                w_count;
    logic                w_lerr_next;
    logic [DIGITS-1:0]   w_carry;
    logic                w_rollover;

    assign w_new_mod  = (bus.Mod < c_min_mod) ? c_min_mod : bus.Mod;
    // A load in the same cycle as a modulus write clamps against the new modulus
    assign w_eff_mod  = bus.ModWr ? w_new_mod : r_mod;
    assign w_mod_m1   = r_mod - c_one;
    assign w_eff_m1   = w_eff_mod - c_one;
    assign w_count    = bus.En & ~bus.Clear & ~bus.Load & ~bus.ModWr;
    assign w_rollover = &w_carry;

    always_comb begin : p_next
        logic [W-1:0] v_d;
        logic [W-1:0] v_ld;
        logic [W-1:0] v_nd;
        logic         v_term;
        logic         v_allow;
        w_q_next    = r_q;
        w_carry     = '0;
        w_lerr_next = 1'b0;
        v_allow     = 1'b1;
        v_d         = '0;
        v_ld        = '0;
        v_nd        = '0;
        v_term      = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            v_d    = r_q[i*W +: W];
            v_ld   = bus.LoadVal[i*W +: W];
            v_term = bus.Up ? (v_d == w_mod_m1) : (v_d == '0);
            v_nd   = v_d;
            if (bus.Clear) begin
                v_nd = '0;
            end else if (bus.ModWr || bus.Load) begin
                if (bus.ModWr && (v_d >= w_new_mod)) begin
                    v_nd = '0;
                end
                if (bus.Load) begin
                    if (v_ld >= w_eff_mod) begin
                        v_nd        = w_eff_m1;
                        w_lerr_next = 1'b1;
                    end else begin
                        v_nd = v_ld;
                    end
                end
            end else if (w_count && v_allow) begin
                w_carry[i] = v_term;
                if (bus.Up) begin
                    v_nd = v_term ? '0 : v_d + c_one;
                end else begin
                    v_nd = v_term ? w_mod_m1 : v_d - c_one;
                end
            end
            // Higher digits step only while every digit below sits at its terminal value
            v_allow = v_allow & v_term;
            w_q_next[i*W +: W] = v_nd;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_q    <= '0;
            r_mod  <= c_reset_mod;
            r_ovf  <= 1'b0;
            r_lerr <= 1'b0;
        end else if (bus.Clear) begin
            r_q    <= '0;
            r_ovf  <= 1'b0;
            r_lerr <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            if (bus.ModWr) begin
                r_mod <= w_new_mod;
            end
            if (w_rollover) begin
                r_ovf <= 1'b1;
            end
            r_lerr <= bus.Load & w_lerr_next;
        end
    end

    assign bus.Q          = r_q;
    assign bus.ModCur     = r_mod;
    assign bus.Overflow   = r_ovf;
    assign bus.LoadErr    = r_lerr;
    assign bus.DigitCarry = w_carry;
    assign bus.Rollover   = w_rollover;
endmodule
`default_nettype wire

// File: tb/tb_cascaded_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cascaded_mod_counter
// Brief    : Self-checking bench: arithmetic reference model plus directed pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cascaded_mod_counter;
    localparam int D = 2;
    localparam int W = 5;
    localparam int K = 20;

    logic Clk;
    logic Reset;
    int   n_cmp;
    int   n_fail;

    cascaded_mod_counter_if #(.DIGITS(D), .W(W)) bus ();

    cascaded_mod_counter #(.DIGITS(D), .W(W), .K(K)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the count is one integer in base M, digits kept for ModWr/Load.
    int m_d[D];
    int m_mod;
    bit m_ovf;
    bit m_lerr;

    always @(negedge Clk) begin : p_model
        int v, pw, tot, nm, ld;
        bit cc, roll, err;
        logic [D*W-1:0] eq;
        logic [D-1:0]   ecar;
        if (!Reset) begin
            chk("rst_q", int'(bus.Q), 0);
            chk("rst_mod", int'(bus.ModCur), K);
            chk("rst_ovf", int'(bus.Overflow), 0);
            chk("rst_lerr", int'(bus.LoadErr), 0);
            for (int i = 0; i < D; i++) m_d[i] = 0;
            m_mod  = K;
            m_ovf  = 0;
            m_lerr = 0;
        end else begin
            eq = '0;
            v  = 0;
            pw = 1;
            for (int i = 0; i < D; i++) begin
                eq[i*W +: W] = W'(m_d[i]);
                v  += m_d[i] * pw;
                pw *= m_mod;
            end
            tot = pw;
            cc  = bus.En && !bus.Clear && !bus.Load && !bus.ModWr;
            ecar = '0;
            pw   = 1;
            for (int i = 0; i < D; i++) begin
                pw *= m_mod;
                ecar[i] = cc && (bus.Up ? ((v % pw) == pw - 1) : ((v % pw) == 0));
            end
            roll = cc && (bus.Up ? (v == tot - 1) : (v == 0));
            chk("q", int'(bus.Q), int'(eq));
            chk("modcur", int'(bus.ModCur), m_mod);
            chk("overflow", int'(bus.Overflow), int'(m_ovf));
            chk("loaderr", int'(bus.LoadErr), int'(m_lerr));
            chk("digitcarry", int'(bus.DigitCarry), int'(ecar));
            chk("rollover", int'(bus.Rollover), int'(roll));
            if (bus.Clear) begin
                for (int i = 0; i < D; i++) m_d[i] = 0;
                m_ovf  = 0;
                m_lerr = 0;
            end else if (bus.ModWr || bus.Load) begin
                nm  = bus.ModWr ? ((int'(bus.Mod) < 2) ? 2 : int'(bus.Mod)) : m_mod;
                err = 0;
                for (int i = 0; i < D; i++) begin
                    if (bus.ModWr && m_d[i] >= nm) m_d[i] = 0;
                    if (bus.Load) begin
                        ld = int'(bus.LoadVal[i*W +: W]);
                        if (ld > nm - 1) begin
                            m_d[i] = nm - 1;
                            err = 1;
                        end else begin
                            m_d[i] = ld;
                        end
                    end
                end
                m_mod  = nm;
                m_lerr = bus.Load && err;
            end else begin
                if (cc) begin
                    v = bus.Up ? (v + 1) % tot : (v + tot - 1) % tot;
                    for (int i = 0; i < D; i++) begin
                        m_d[i] = v % m_mod;
                        v      = v / m_mod;
                    end
                end
                if (roll) m_ovf = 1;
                m_lerr = 0;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic drive(input logic en, input logic up, input logic clr, input logic ld,
                         input logic [D*W-1:0] lv, input logic mw, input logic [W-1:0] md);
        bus.En      = en;
        bus.Up      = up;
        bus.Clear   = clr;
        bus.Load    = ld;
        bus.LoadVal = lv;
        bus.ModWr   = mw;
        bus.Mod     = md;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        Reset  = 1'b1;
        drive(0, 1, 0, 0, '0, 0, '0);
        #1 Reset = 1'b0;
        repeat (3) tick();
        chk("pin_rst_q", int'(bus.Q), 0);
        chk("pin_rst_mod", int'(bus.ModCur), 20);

        // Up-count through the whole chain
        Reset = 1'b1;
        drive(1, 1, 0, 0, '0, 0, '0);
        repeat (19) tick();
        #1;
        chk("pin_up19_q", int'(bus.Q), 19);
        chk("pin_up19_dc", int'(bus.DigitCarry), 1);
        chk("pin_up19_roll", int'(bus.Rollover), 0);
        tick();
        chk("pin_up20_q", int'(bus.Q), 32);
        repeat (379) tick();
        #1;
        chk("pin_up399_q", int'(bus.Q), 19 * 32 + 19);
        chk("pin_up399_roll", int'(bus.Rollover), 1);
        tick();
        chk("pin_up400_q", int'(bus.Q), 0);
        chk("pin_up400_ovf", int'(bus.Overflow), 1);

        // Down-count wrap from zero
        drive(0, 1, 1, 0, '0, 0, '0);
        tick();
        chk("pin_clr_ovf", int'(bus.Overflow), 0);
        drive(1, 0, 0, 0, '0, 0, '0);
        #1;
        chk("pin_dn_roll", int'(bus.Rollover), 1);
        tick();
        chk("pin_dn_q", int'(bus.Q), 19 * 32 + 19);
        chk("pin_dn_ovf", int'(bus.Overflow), 1);
        tick();
        chk("pin_dn2_q", int'(bus.Q), 19 * 32 + 18);

        // Load with and without clamping
        drive(0, 1, 0, 1, 10'(3 * 32 + 25), 0, '0);
        tick();
        chk("pin_ld_q", int'(bus.Q), 3 * 32 + 19);
        chk("pin_ld_err", int'(bus.LoadErr), 1);
        drive(0, 1, 0, 1, 10'(3 * 32 + 4), 0, '0);
        tick();
        chk("pin_ld2_q", int'(bus.Q), 3 * 32 + 4);
        chk("pin_ld2_err", int'(bus.LoadErr), 0);

        // Modulus write trims out-of-range digits and suppresses counting
        drive(0, 1, 0, 1, 10'(12 * 32 + 5), 0, '0);
        tick();
        drive(1, 1, 0, 0, '0, 1, 5'd10);
        tick();
        chk("pin_mw_q", int'(bus.Q), 5);
        chk("pin_mw_mod", int'(bus.ModCur), 10);
        drive(1, 1, 0, 0, '0, 0, '0);
        repeat (4) tick();
        chk("pin_m10_q9", int'(bus.Q), 9);
        tick();
        chk("pin_m10_q10", int'(bus.Q), 32);
        drive(0, 1, 0, 0, '0, 1, 5'd1);
        tick();
        chk("pin_mod_clamp", int'(bus.ModCur), 2);

        // Clear beats Load and En
        drive(1, 1, 0, 0, '0, 0, '0);
        repeat (4) tick();
        chk("pin_m2_ovf", int'(bus.Overflow), 1);
        drive(1, 1, 1, 1, 10'h3FF, 0, '0);
        tick();
        chk("pin_clr_q", int'(bus.Q), 0);
        chk("pin_clr_ovf2", int'(bus.Overflow), 0);
        chk("pin_clr_mod", int'(bus.ModCur), 2);

        // Asynchronous reset mid-count
        drive(0, 1, 0, 0, '0, 1, 5'd20);
        tick();
        drive(0, 1, 0, 1, 10'(7 * 32 + 3), 0, '0);
        tick();
        drive(1, 1, 0, 0, '0, 0, '0);
        chk("pin_pre_rst_q", int'(bus.Q), 7 * 32 + 3);
        Reset = 1'b0;
        #1;
        chk("pin_async_q", int'(bus.Q), 0);
        chk("pin_async_mod", int'(bus.ModCur), 20);
        #1;
        tick();
        Reset = 1'b1;
        tick();
        chk("pin_restart_q", int'(bus.Q), 1);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            tick();
            if (!Reset) begin
                Reset = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                Reset = 1'b0;
            end
            bus.En      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) bus.Up = ~bus.Up;
            bus.Clear   = ($urandom_range(0, 63) == 0);
            bus.Load    = ($urandom_range(0, 23) == 0);
            bus.LoadVal = 10'($urandom);
            bus.ModWr   = ($urandom_range(0, 39) == 0);
            bus.Mod     = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 6)) : 5'($urandom);
        end
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
